// File: rtl/spi_arbiter.sv
// Hands the shared SPI master to init, scene or player with registered one-hot selects.
// Init has priority over the others, scene and player alternate, and an idle gap separates owners.
module spi_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_HOLD   = 0,
    parameter int HOLD_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       scene_req,
    input  logic       player_req,
    input  logic       spi_busy,
    output logic       init_enable,
    output logic       scene_enable,
    output logic       player_enable,
    output logic [1:0] owner,
    output logic       arb_busy,
    output logic       hold_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_INIT   = 2'd1;
    localparam logic [1:0] OWN_SCENE  = 2'd2;
    localparam logic [1:0] OWN_PLAYER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic               rr_player_q, rr_player_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               timeout_q, timeout_d;
    logic               busy_q;
    logic               init_en_q, scene_en_q, player_en_q;
    logic               own_req;

    always_comb begin
        own_req = 1'b0;
        case (owner_q)
            OWN_INIT:   own_req = init_req;
            OWN_SCENE:  own_req = scene_req;
            OWN_PLAYER: own_req = player_req;
            default:    own_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_player_d = rr_player_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                hold_d  = '0;
                // rr_player_q set means player went last, so scene takes a tie.
                if (init_req) begin
                    owner_d = OWN_INIT;
                    state_d = ST_GRANT;
                end else if (scene_req && (!player_req || rr_player_q)) begin
                    owner_d     = OWN_SCENE;
                    rr_player_d = 1'b0;
                    state_d     = ST_GRANT;
                end else if (player_req) begin
                    owner_d     = OWN_PLAYER;
                    rr_player_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (hold_q != {HOLD_W{1'b1}}) begin
                    hold_d = hold_q + 1'b1;
                end
                if (!own_req) begin
                    state_d = ST_DRAIN;
                end else if (MAX_HOLD > 0 && hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = ST_DRAIN;
                    timeout_d = 1'b1;
                end
            end

            // Select stays on so the owner's last byte still reaches the pins.
            ST_DRAIN: begin
                if (!spi_busy) begin
                    owner_d = OWN_NONE;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end

            ST_GAP: begin
                owner_d = OWN_NONE;
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            rr_player_q <= 1'b1;
            hold_q      <= '0;
            gap_q       <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            init_en_q   <= 1'b0;
            scene_en_q  <= 1'b0;
            player_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_player_q <= rr_player_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            timeout_q   <= timeout_d;
            busy_q      <= (state_d != ST_IDLE);
            init_en_q   <= (owner_d == OWN_INIT);
            scene_en_q  <= (owner_d == OWN_SCENE);
            player_en_q <= (owner_d == OWN_PLAYER);
        end
    end

    assign init_enable   = init_en_q;
    assign scene_enable  = scene_en_q;
    assign player_enable = player_en_q;
    assign owner         = owner_q;
    assign arb_busy      = busy_q;
    assign hold_timeout  = timeout_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: three parameterisations share one stimulus stream.
module tb_spi_arbiter;

    logic clk = 1'b0;
    logic rst, init_req, scene_req, player_req, spi_busy;

    always #5 clk = ~clk;

    // Default (gap 4, no timeout), timeout 8, and zero-gap variants.
    logic       a_ie, a_se, a_pe, a_busy, a_to;
    logic [1:0] a_own;
    logic       t_ie, t_se, t_pe, t_busy, t_to;
    logic [1:0] t_own;
    logic       n_ie, n_se, n_pe, n_busy, n_to;
    logic [1:0] n_own;

    spi_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(0), .HOLD_W(16)) u_dflt (
        .clk(clk), .rst(rst), .init_req(init_req), .scene_req(scene_req),
        .player_req(player_req), .spi_busy(spi_busy),
        .init_enable(a_ie), .scene_enable(a_se), .player_enable(a_pe),
        .owner(a_own), .arb_busy(a_busy), .hold_timeout(a_to));

    spi_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(8), .HOLD_W(16)) u_to (
        .clk(clk), .rst(rst), .init_req(init_req), .scene_req(scene_req),
        .player_req(player_req), .spi_busy(spi_busy),
        .init_enable(t_ie), .scene_enable(t_se), .player_enable(t_pe),
        .owner(t_own), .arb_busy(t_busy), .hold_timeout(t_to));

    spi_arbiter #(.GAP_CYCLES(0), .MAX_HOLD(0), .HOLD_W(16)) u_ng (
        .clk(clk), .rst(rst), .init_req(init_req), .scene_req(scene_req),
        .player_req(player_req), .spi_busy(spi_busy),
        .init_enable(n_ie), .scene_enable(n_se), .player_enable(n_pe),
        .owner(n_own), .arb_busy(n_busy), .hold_timeout(n_to));

    // {init_enable, scene_enable, player_enable, owner, arb_busy}
    wire [5:0] a_out = {a_ie, a_se, a_pe, a_own, a_busy};
    wire [5:0] t_out = {t_ie, t_se, t_pe, t_own, t_busy};
    wire [5:0] n_out = {n_ie, n_se, n_pe, n_own, n_busy};

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_GAP    = 6'b000001;
    localparam logic [5:0] C_INIT   = 6'b100011;
    localparam logic [5:0] C_SCENE  = 6'b010101;
    localparam logic [5:0] C_PLAYER = 6'b001111;

    int errors = 0;
    int checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        init_req = 0; scene_req = 0; player_req = 0; spi_busy = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (a_out !== C_IDLE) begin errors++; $display("FAIL reset_dflt: got %b want %b", a_out, C_IDLE); end
        checks++; if (t_out !== C_IDLE) begin errors++; $display("FAIL reset_to: got %b want %b", t_out, C_IDLE); end
        checks++; if (n_out !== C_IDLE) begin errors++; $display("FAIL reset_ng: got %b want %b", n_out, C_IDLE); end
        checks++; if ({a_to, t_to, n_to} !== 3'b000) begin errors++; $display("FAIL reset_timeout: got %b want 000", {a_to, t_to, n_to}); end
    endtask

    task automatic test_init_grant;
        do_reset();
        tick();
        init_req = 1;
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++; if (a_out !== C_INIT) begin errors++; $display("FAIL init_grant[%0d]: got %b want %b", i, a_out, C_INIT); end
            tick();
        end
        checks++; if (a_out !== C_INIT) begin errors++; $display("FAIL init_grant_last: got %b want %b", a_out, C_INIT); end
        init_req = 0;
        tick();
        checks++; if (a_out !== C_INIT) begin errors++; $display("FAIL init_drain: got %b want %b", a_out, C_INIT); end
        checks++; if (n_out !== C_INIT) begin errors++; $display("FAIL init_drain_ng: got %b want %b", n_out, C_INIT); end
        tick();
        checks++; if (n_out !== C_IDLE) begin errors++; $display("FAIL nogap_idle: got %b want %b", n_out, C_IDLE); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out !== C_GAP) begin errors++; $display("FAIL init_gap[%0d]: got %b want %b", i, a_out, C_GAP); end
            tick();
        end
        checks++; if (a_out !== C_IDLE) begin errors++; $display("FAIL init_idle: got %b want %b", a_out, C_IDLE); end
    endtask

    task automatic test_round_robin;
        logic [5:0] code;
        do_reset();
        scene_req = 1; player_req = 1;
        for (int k = 0; k < 3; k++) begin
            code = (k == 1) ? C_PLAYER : C_SCENE;
            tick();
            for (int j = 0; j < 5; j++) begin
                checks++; if (a_out !== code) begin errors++; $display("FAIL rr_grant%0d[%0d]: got %b want %b", k, j, a_out, code); end
                if (j < 4) tick();
            end
            if (k == 1) player_req = 0; else scene_req = 0;
            tick();
            checks++; if (a_out !== code) begin errors++; $display("FAIL rr_drain%0d: got %b want %b", k, a_out, code); end
            scene_req = 1; player_req = 1;
            for (int g = 0; g < 4; g++) begin
                tick();
                checks++; if (a_out !== C_GAP) begin errors++; $display("FAIL rr_gap%0d[%0d]: got %b want %b", k, g, a_out, C_GAP); end
            end
            tick();
            checks++; if (a_out !== C_IDLE) begin errors++; $display("FAIL rr_idle%0d: got %b want %b", k, a_out, C_IDLE); end
        end
    endtask

    task automatic test_no_preempt;
        do_reset();
        scene_req = 1;
        tick();
        tick();
        init_req = 1; player_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (a_out !== C_SCENE) begin errors++; $display("FAIL nopreempt_hold[%0d]: got %b want %b", i, a_out, C_SCENE); end
        end
        scene_req = 0;
        tick();
        checks++; if (a_out !== C_SCENE) begin errors++; $display("FAIL nopreempt_drain: got %b want %b", a_out, C_SCENE); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (a_out !== C_IDLE) begin errors++; $display("FAIL nopreempt_idle: got %b want %b", a_out, C_IDLE); end
        tick();
        checks++; if (a_out !== C_INIT) begin errors++; $display("FAIL nopreempt_init_first: got %b want %b", a_out, C_INIT); end
    endtask

    task automatic test_drain_busy;
        do_reset();
        player_req = 1;
        tick();
        checks++; if (a_out !== C_PLAYER) begin errors++; $display("FAIL drain_grant: got %b want %b", a_out, C_PLAYER); end
        tick();
        player_req = 0; spi_busy = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (a_out !== C_PLAYER) begin errors++; $display("FAIL drain_hold[%0d]: got %b want %b", i, a_out, C_PLAYER); end
        end
        spi_busy = 0;
        tick();
        checks++; if (a_out !== C_GAP) begin errors++; $display("FAIL drain_release: got %b want %b", a_out, C_GAP); end
    endtask

    task automatic test_timeout;
        do_reset();
        player_req = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if ({t_out, t_to} !== {C_PLAYER, 1'b0}) begin errors++; $display("FAIL to_grant[%0d]: got %b/%b want %b/0", i, t_out, t_to, C_PLAYER); end
            tick();
        end
        checks++; if ({t_out, t_to} !== {C_PLAYER, 1'b1}) begin errors++; $display("FAIL to_pulse: got %b/%b want %b/1", t_out, t_to, C_PLAYER); end
        checks++; if ({a_out, a_to} !== {C_PLAYER, 1'b0}) begin errors++; $display("FAIL to_disabled: got %b/%b want %b/0", a_out, a_to, C_PLAYER); end
        tick();
        checks++; if ({t_out, t_to} !== {C_GAP, 1'b0}) begin errors++; $display("FAIL to_gap: got %b/%b want %b/0", t_out, t_to, C_GAP); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (t_out !== C_IDLE) begin errors++; $display("FAIL to_idle: got %b want %b", t_out, C_IDLE); end
        tick();
        checks++; if (t_out !== C_PLAYER) begin errors++; $display("FAIL to_regrant: got %b want %b", t_out, C_PLAYER); end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        scene_req = 1; player_req = 1;
        tick();
        checks++; if (a_out !== C_SCENE) begin errors++; $display("FAIL rst_first: got %b want %b", a_out, C_SCENE); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++; if ({a_out, a_to} !== 7'b0) begin errors++; $display("FAIL rst_in_grant: got %b want 0", {a_out, a_to}); end
        checks++; if (n_out !== C_IDLE) begin errors++; $display("FAIL rst_in_grant_ng: got %b want %b", n_out, C_IDLE); end
        tick();
        checks++; if (a_out !== C_SCENE) begin errors++; $display("FAIL rst_rr_grant: got %b want %b", a_out, C_SCENE); end
        scene_req = 0;
        tick();
        tick();
        tick();
        checks++; if (a_out !== C_GAP) begin errors++; $display("FAIL rst_pre_gap: got %b want %b", a_out, C_GAP); end
        checks++; if (n_out !== C_PLAYER) begin errors++; $display("FAIL ng_fast_regrant: got %b want %b", n_out, C_PLAYER); end
        rst = 1;
        tick();
        rst = 0;
        scene_req = 1;
        checks++; if (a_out !== C_IDLE) begin errors++; $display("FAIL rst_in_gap: got %b want %b", a_out, C_IDLE); end
        checks++; if (n_out !== C_IDLE) begin errors++; $display("FAIL rst_in_gap_ng: got %b want %b", n_out, C_IDLE); end
        tick();
        checks++; if (a_out !== C_SCENE) begin errors++; $display("FAIL rst_gap_rr: got %b want %b", a_out, C_SCENE); end
        checks++; if (n_out !== C_SCENE) begin errors++; $display("FAIL rst_gap_rr_ng: got %b want %b", n_out, C_SCENE); end
    endtask

    initial begin
        rst = 1; init_req = 0; scene_req = 0; player_req = 0; spi_busy = 0;
        test_reset();
        test_init_grant();
        test_round_robin();
        test_no_preempt();
        test_drain_busy();
        test_timeout();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
